sa_feed_sched: RTL and testbench
================================

# sa_feed_sched

Tile-level scheduler for the systolic-array operand feed. It takes one command per tile and accepts K operand vectors from the operand source over a valid/ready handshake. It then drives the per-row `in_valid` enables of the row skew shift registers, delaying row r by r cycles. After the last vector it injects zero-fill flush beats so every row's final operand leaves its shift register, then pulses `done`.

## Interface
- `ROWS`, default 8: number of array rows, i.e. the number of shift registers driven; must be ≥1.
- `DEPTH`, default 27: buffer size of each row shift register.
- `K_WIDTH`, default 16: width of the vector-count field.
- `clk`, in, 1: clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `start`, in, 1: tile command strobe.
- `k_len`, in, K_WIDTH: vectors per tile. Sampled only on an accepted `start`.
- `stall`, in, 1: array backpressure. While high, blocks new injects.
- `src_valid`, in, 1: operand source has a vector.
- `src_ready`, out, 1: scheduler accepts a vector this cycle.
- `row_shift_en`, out, ROWS: per-row `in_valid` for the row shift registers.
- `row_zero_fill`, out, ROWS: per-row data mux select. 1 means feed 0 instead of operand data.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle tile-complete pulse.

## Operation
- **States:** IDLE, STREAM, DRAIN, SETTLE, DONE.
- **IDLE:**
  - `start`=1 with `k_len`≠0: latch `k_len`, clear counters, go to STREAM.
  - `start` with `k_len`=0 is ignored and the block stays IDLE.
  - `start` in any other state is ignored.
- **STREAM:**
  - `src_ready` = !`stall`.
  - accept = `src_valid` & `src_ready`. Each accept is one inject with zero_fill=0 and increments the beat counter.
  - On the accept that makes beat count = `k_len`, go to DRAIN.
- **DRAIN:**
  - `src_ready`=0.
  - Each cycle with !`stall` is one inject with zero_fill=1 and increments the drain counter.
  - After DEPTH+1 drain injects, go to SETTLE. If ROWS=1, go straight to DONE.
- **SETTLE:**
  - No injects. Counts ROWS-1 cycles regardless of `stall`, then goes to DONE.
- **DONE:**
  - `done`=1 for one cycle, then IDLE.
- **Row skew:**
  - `row_shift_en[0]` = inject. It is combinational from state, `stall` and the handshake.
  - `row_zero_fill[0]` = inject & zero_fill.
  - Row r outputs are the row-0 values delayed by r registered stages. The delay line advances every cycle, including stall cycles, so the skew is exact.
- **Counter widths:**
  - Beat counter: K_WIDTH bits, no wrap; the terminal compare is equality with the latched `k_len`.
  - Drain counter: clog2(DEPTH+2) bits.
  - Settle counter: clog2(ROWS) bits, minimum 1.
- **Flush rationale:** data injected at enable n reaches shift-register `data_out` at enable n+DEPTH+1. DEPTH+1 flush beats therefore empty every row.
- **Reset:** `rst`=1 at any point, including mid-tile, does the following at that edge:
  - state ← IDLE
  - counters ← 0
  - skew delay line ← 0
  - the partial tile is dropped.

## Timing
- **Reset values:**
  - `src_ready`=0, `row_shift_en`=0, `row_zero_fill`=0, `busy`=0, `done`=0.
  - These registered outputs are forced low while `rst` is high.
- **Start latency:** `start` sampled at edge 0 gives STREAM in cycle 1, with `src_ready` and `busy` high in cycle 1.
- **Tile length without stall:** with `src_valid` held high, the tile lasts 1 + k_len + (DEPTH+1) + (ROWS-1) + 1 cycles from `start` to `done` inclusive.
- **Last-row enable:** the last row's final enable is the cycle immediately before `done`.
- **Stall:** each `stall` cycle in STREAM or DRAIN adds exactly one cycle. `stall` in SETTLE or DONE has no effect.
- **Source backpressure:** a cycle with `src_valid`=0 in STREAM adds one cycle with no inject.
- **`busy`:** falls in the cycle after DONE.
- **Back-to-back tiles:** a new `start` is accepted in that IDLE cycle, giving a minimum one-cycle gap between tiles.

## Test plan
1. **Basic tile:** ROWS=4, DEPTH=3, `k_len`=2, `src_valid`=1, no stall, `start` at cycle 0. Required:
   - `src_ready` high in cycles 1–2.
   - `row_shift_en[0]` high in cycles 1–6; `row_zero_fill[0]` high in cycles 3–6.
   - `row_shift_en[3]` high in cycles 4–9.
   - `done` only in cycle 10; `busy` high in cycles 1–10.
2. **Stalls:** same setup with `stall`=1 in cycle 2 and cycle 4. Required:
   - the second accept moves to cycle 3;
   - no inject in cycles 2 and 4;
   - `done` in cycle 12;
   - the row-3 enable pattern equals row 0 shifted by 3 cycles.
3. **Source gaps:** `src_valid` toggles 1,0,1 with `k_len`=2. Required: accepts in cycles 1 and 3, and `done` one cycle later than scenario 1.
4. **Ignored starts:** `start` with `k_len`=0, then `start` pulsed while busy. Required: no state change and `busy` stays 0 for the first; the mid-tile start has no effect on counts or on `done` timing.
5. **Reset mid-tile:** `rst`=1 in cycle 5 of scenario 1. Required:
   - all outputs 0 from cycle 6;
   - no `done`;
   - a fresh `start` in cycle 7 reproduces the scenario-1 timeline shifted by 7 cycles.
6. **Single row:** ROWS=1, DEPTH=3, `k_len`=1. Required: `row_shift_en[0]` high in cycles 1–5, `done` in cycle 6 (SETTLE skipped).

Source files
------------

// File: rtl/sa_feed_sched.sv
// sa_feed_sched
//   Tile-level scheduler for the systolic-array operand feed. One command per
//   tile: accepts k_len operand vectors from the source, then injects DEPTH+1
//   zero-fill flush beats, waits ROWS-1 cycles for the row skew to drain and
//   pulses done. Row r enables are the row-0 enables delayed by r cycles.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start, k_len    : tile command strobe and vectors per tile (k_len=0 ignored)
//   stall           : array backpressure, blocks injects in STREAM/DRAIN
//   src_valid       : operand source has a vector
//   src_ready       : scheduler accepts a vector this cycle
//   row_shift_en    : per-row in_valid for the row skew shift registers
//   row_zero_fill   : per-row mux select, 1 = feed zero instead of operand
//   busy            : high in every state except IDLE
//   done            : one-cycle tile-complete pulse
module sa_feed_sched #(
  parameter int ROWS    = 8,
  parameter int DEPTH   = 27,
  parameter int K_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k_len,
  input  logic               stall,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [ROWS-1:0]    row_shift_en,
  output logic [ROWS-1:0]    row_zero_fill,
  output logic               busy,
  output logic               done
);

  localparam int DRN_W = $clog2(DEPTH + 2);
  localparam int SET_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DEPTH);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((ROWS > 1) ? ROWS - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [K_WIDTH-1:0] k_lat;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [DRN_W-1:0]   drn_cnt;
  logic [SET_W-1:0]   set_cnt;
  logic               tile_go;
  logic               accept;
  logic               flush;
  logic               vld_p0;
  logic               zf_p0;
  logic [ROWS-1:0]    row_vld;
  logic [ROWS-1:0]    row_zf;

  assign tile_go = start && (k_len != '0);

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    flush     = 1'b0;
    src_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (tile_go) state_nx = S_STREAM;
      end
      S_STREAM: begin
        src_ready = !stall;
        accept    = src_valid && !stall;
        if (accept && (K_WIDTH'(beat_cnt + 1'b1) == k_lat)) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        flush = !stall;
        if (flush && (drn_cnt == DRN_LAST)) state_nx = (ROWS > 1) ? S_SETTLE : S_DONE;
      end
      S_SETTLE: begin
        if (set_cnt == SET_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    // Reset cycle: nothing is offered to the source or the array.
    if (rst) begin
      src_ready = 1'b0;
      accept    = 1'b0;
      flush     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      drn_cnt  <= '0;
      set_cnt  <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && tile_go) begin
        beat_cnt <= '0;
        drn_cnt  <= '0;
        set_cnt  <= '0;
      end
      if (accept) beat_cnt <= beat_cnt + 1'b1;
      if (flush) drn_cnt <= drn_cnt + 1'b1;
      if (state == S_SETTLE) set_cnt <= set_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && tile_go) k_lat <= k_len;
  end

  // Stage p0: row-0 inject, combinational from state, stall and handshake
  assign vld_p0 = accept || flush;
  assign zf_p0  = flush;

  // Stages p1..p(ROWS-1): skew delay line, advances every cycle including stalls
  if (ROWS > 1) begin : g_skew
    localparam int SK_W = ROWS - 1;
    logic [SK_W-1:0] vld_pn;
    logic [SK_W-1:0] zf_pn;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pn <= '0;
        zf_pn  <= '0;
      end else begin
        vld_pn <= SK_W'({vld_pn, vld_p0});
        zf_pn  <= SK_W'({zf_pn, zf_p0});
      end
    end

    assign row_vld = {vld_pn, vld_p0};
    assign row_zf  = {zf_pn, zf_p0};
  end else begin : g_flat
    assign row_vld = vld_p0;
    assign row_zf  = zf_p0;
  end

  assign row_shift_en  = rst ? '0 : row_vld;
  assign row_zero_fill = rst ? '0 : row_zf;
  assign busy          = !rst && (state != S_IDLE);
  assign done          = !rst && (state == S_DONE);

endmodule

// File: tb/tb_sa_feed_sched.sv
module tb_sa_feed_sched;

  localparam int NCYC = 1500;
  localparam int KW   = 8;
  localparam int DEP  = 3;

  localparam int M_IDLE   = 0;
  localparam int M_FETCH  = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_SETTLE = 3;
  localparam int M_DONE   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          stall;
  logic          src_valid;

  logic          src_ready_a, busy_a, done_a;
  logic [3:0]    en_a, zf_a;
  logic          src_ready_b, busy_b, done_b;
  logic [0:0]    en_b, zf_b;

  sa_feed_sched #(.ROWS(4), .DEPTH(DEP), .K_WIDTH(KW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
    .src_valid(src_valid), .src_ready(src_ready_a), .row_shift_en(en_a),
    .row_zero_fill(zf_a), .busy(busy_a), .done(done_a)
  );

  sa_feed_sched #(.ROWS(1), .DEPTH(DEP), .K_WIDTH(KW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall),
    .src_valid(src_valid), .src_ready(src_ready_b), .row_shift_en(en_b),
    .row_zero_fill(zf_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // stimulus per cycle
  bit st_rst   [NCYC];
  bit st_start [NCYC];
  bit st_stall [NCYC];
  bit st_valid [NCYC];
  int st_k     [NCYC];

  // expected per config (0: ROWS=4, 1: ROWS=1)
  int inj0     [2][NCYC];
  int exp_rdy  [2][NCYC];
  int exp_en   [2][NCYC];
  int exp_zf   [2][NCYC];
  int exp_busy [2][NCYC];
  int exp_done [2][NCYC];
  bit obs_done [2][NCYC];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Tile described as work remaining: k vectors from the source, DEPTH+1
  // unstalled flush beats, ROWS-1 settle cycles, then one done cycle.
  task automatic model(input int cfg, input int rows, input int depth);
    int mode;
    int rem;
    int last_rst;
    mode     = M_IDLE;
    rem      = 0;
    last_rst = -1;
    for (int c = 0; c < NCYC; c++) begin
      int en;
      int zf;
      en = 0;
      zf = 0;
      inj0[cfg][c]     = 0;
      exp_rdy[cfg][c]  = 0;
      exp_busy[cfg][c] = 0;
      exp_done[cfg][c] = 0;
      if (st_rst[c]) begin
        mode     = M_IDLE;
        last_rst = c;
      end else begin
        int zf0;
        zf0 = 0;
        exp_busy[cfg][c] = (mode != M_IDLE);
        exp_done[cfg][c] = (mode == M_DONE);
        case (mode)
          M_IDLE: begin
            if (st_start[c] && st_k[c] != 0) begin
              mode = M_FETCH;
              rem  = st_k[c];
            end
          end
          M_FETCH: begin
            exp_rdy[cfg][c] = !st_stall[c];
            if (st_valid[c] && !st_stall[c]) begin
              inj0[cfg][c] = 1;
              rem--;
              if (rem == 0) begin
                mode = M_FLUSH;
                rem  = depth + 1;
              end
            end
          end
          M_FLUSH: begin
            if (!st_stall[c]) begin
              inj0[cfg][c] = 1;
              zf0 = 1;
              rem--;
              if (rem == 0) begin
                if (rows > 1) begin
                  mode = M_SETTLE;
                  rem  = rows - 1;
                end else begin
                  mode = M_DONE;
                end
              end
            end
          end
          M_SETTLE: begin
            rem--;
            if (rem == 0) mode = M_DONE;
          end
          default: mode = M_IDLE;
        endcase
        // zero-fill beats are exactly the injects made while flushing
        if (zf0 != 0) inj0[cfg][c] = inj0[cfg][c] | 2;
        for (int r = 0; r < rows; r++) begin
          int src;
          src = c - r;
          if (src > last_rst) begin
            if (inj0[cfg][src] & 1) en = en | (1 << r);
            if (inj0[cfg][src] & 2) zf = zf | (1 << r);
          end
        end
      end
      exp_en[cfg][c] = en;
      exp_zf[cfg][c] = zf;
    end
  endtask

  task automatic put_tile(input int c, input int k, input int vlen);
    st_start[c] = 1'b1;
    st_k[c]     = k;
    for (int i = 1; i <= vlen; i++) st_valid[c + i] = 1'b1;
  endtask

  function automatic int first_done(input int cfg, input int from);
    for (int c = from; c < NCYC; c++) if (obs_done[cfg][c]) return c;
    return -1;
  endfunction

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      st_rst[c] = 0; st_start[c] = 0; st_stall[c] = 0; st_valid[c] = 0; st_k[c] = 0;
      obs_done[0][c] = 0; obs_done[1][c] = 0;
    end
    st_rst[0] = 1'b1;
    st_rst[1] = 1'b1;
    // basic tile
    put_tile(4, 2, 12);
    // stalls in tile cycles 2 and 4
    put_tile(18, 2, 14);
    st_stall[20] = 1'b1;
    st_stall[22] = 1'b1;
    // source gap in tile cycle 2
    put_tile(34, 2, 14);
    st_valid[36] = 1'b0;
    // start with k_len=0, then a tile with a start pulsed mid-tile
    st_start[50] = 1'b1;
    st_k[50]     = 0;
    put_tile(52, 2, 14);
    st_start[55] = 1'b1;
    st_k[55]     = 3;
    // reset in tile cycle 5, fresh start two cycles later
    put_tile(68, 2, 14);
    st_rst[73] = 1'b1;
    put_tile(75, 2, 14);
    // single-element tile
    put_tile(92, 1, 12);
    // random traffic
    for (int c = 106; c < NCYC - 30; c++) begin
      st_start[c] = ($urandom_range(0, 5) == 0);
      st_k[c]     = $urandom_range(0, 4);
      st_stall[c] = ($urandom_range(0, 3) == 0);
      st_valid[c] = ($urandom_range(0, 3) != 0);
      st_rst[c]   = ($urandom_range(0, 127) == 0);
    end

    model(0, 4, DEP);
    model(1, 1, DEP);

    rst = 1'b1; start = 1'b0; k_len = '0; stall = 1'b0; src_valid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      #1;
      rst       = st_rst[c];
      start     = st_start[c];
      k_len     = KW'(st_k[c]);
      stall     = st_stall[c];
      src_valid = st_valid[c];
      @(negedge clk);
      obs_done[0][c] = done_a;
      obs_done[1][c] = done_b;
      chk($sformatf("c%0d rdy_a", c),  32'(src_ready_a), exp_rdy[0][c]);
      chk($sformatf("c%0d en_a", c),   32'(en_a),        exp_en[0][c]);
      chk($sformatf("c%0d zf_a", c),   32'(zf_a),        exp_zf[0][c]);
      chk($sformatf("c%0d busy_a", c), 32'(busy_a),      exp_busy[0][c]);
      chk($sformatf("c%0d done_a", c), 32'(done_a),      exp_done[0][c]);
      chk($sformatf("c%0d rdy_b", c),  32'(src_ready_b), exp_rdy[1][c]);
      chk($sformatf("c%0d en_b", c),   32'(en_b),        exp_en[1][c]);
      chk($sformatf("c%0d zf_b", c),   32'(zf_b),        exp_zf[1][c]);
      chk($sformatf("c%0d busy_b", c), 32'(busy_b),      exp_busy[1][c]);
      chk($sformatf("c%0d done_b", c), 32'(done_b),      exp_done[1][c]);
      @(posedge clk);
    end

    // absolute done cycles for the directed tiles
    chk("basic done rows4",  32'(first_done(0, 4)),  32'(14));
    chk("basic done rows1",  32'(first_done(1, 4)),  32'(11));
    chk("stall done rows4",  32'(first_done(0, 18)), 32'(30));
    chk("gap done rows4",    32'(first_done(0, 34)), 32'(45));
    chk("ignore done rows4", 32'(first_done(0, 50)), 32'(62));
    chk("reset done rows4",  32'(first_done(0, 68)), 32'(85));
    chk("single done rows1", 32'(first_done(1, 92)), 32'(98));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
